// File: rtl/trap_ctrl.sv
// trap_ctrl: arbitrates pipeline exceptions against masked interrupts and runs the trap handshake.
// Vectored mtvec dispatch for interrupts is enabled by defining TRAP_VECTORED_EN.
module trap_ctrl #(
    parameter int XLEN       = 32,
    parameter int NUM_STAGES = 3,
    parameter int NUM_IRQ    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_STAGES*XLEN-1:0] stage_pc,
    input  logic [NUM_STAGES-1:0]      exc_valid,
    input  logic [NUM_STAGES*XLEN-1:0] exc_cause,
    input  logic [NUM_STAGES*XLEN-1:0] exc_val,
    input  logic [NUM_IRQ-1:0]         irq_pending,
    input  logic [NUM_IRQ-1:0]         irq_enable,
    input  logic                       global_ie,
    input  logic [XLEN-1:0]            mtvec,
    input  logic                       trap_insert,
    input  logic                       mret,
    output logic                       trap_req,
    output logic [XLEN-1:0]            trap_pc,
    output logic [XLEN-1:0]            trap_epc,
    output logic [XLEN-1:0]            trap_cause,
    output logic [XLEN-1:0]            trap_val,
    output logic [NUM_STAGES-1:0]      squash,
    output logic                       in_handler
);
    localparam int SW = NUM_STAGES > 1 ? $clog2(NUM_STAGES) : 1;
    localparam int IW = NUM_IRQ > 1 ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {IDLE, PENDING, HANDLER} state_t;

    state_t              state, state_nx;
    logic [SW-1:0]       exc_sel, lat_stage;
    logic [IW-1:0]       irq_sel;
    logic [NUM_IRQ-1:0]  eff;
    logic [NUM_STAGES-1:0] sq_mask;
    logic                lat_irq, any_exc, any_irq, cap_exc, cap_irq;
    logic [XLEN-1:0]     base;

    assign eff     = irq_pending & irq_enable & {NUM_IRQ{global_ie}};
    assign any_exc = |exc_valid;
    assign any_irq = |eff;

    // Oldest stage (highest index) wins among exceptions; lowest line wins among interrupts.
    always_comb begin
        exc_sel = '0;
        for (int i = 0; i < NUM_STAGES; i++)
            if (exc_valid[i]) exc_sel = SW'(i);
        irq_sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (eff[i]) irq_sel = IW'(i);
        sq_mask = '0;
        for (int i = 0; i < NUM_STAGES; i++)
            sq_mask[i] = i <= int'(exc_sel);
    end

    assign cap_exc = any_exc && (state != PENDING || lat_irq || exc_sel > lat_stage);
    assign cap_irq = state == IDLE && !any_exc && any_irq;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = any_exc || any_irq ? PENDING : IDLE;
            PENDING: state_nx = trap_insert ? HANDLER : PENDING;
            HANDLER: state_nx = any_exc ? PENDING : mret ? IDLE : HANDLER;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        trap_req   = state == PENDING;
        in_handler = state == HANDLER;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trap_epc   <= '0;
            trap_cause <= '0;
            trap_val   <= '0;
            squash     <= '0;
            lat_stage  <= '0;
            lat_irq    <= 1'b0;
        end else begin
            squash <= '0;
            if (cap_exc) begin
                trap_epc   <= stage_pc[exc_sel*XLEN +: XLEN];
                trap_cause <= exc_cause[exc_sel*XLEN +: XLEN];
                trap_val   <= exc_val[exc_sel*XLEN +: XLEN];
                squash     <= sq_mask;
                lat_stage  <= exc_sel;
                lat_irq    <= 1'b0;
            end else if (cap_irq) begin
                trap_epc   <= stage_pc[XLEN-1:0];
                trap_cause <= {1'b1, (XLEN-1)'(irq_sel)};
                trap_val   <= '0;
                lat_stage  <= '0;
                lat_irq    <= 1'b1;
            end
        end
    end

    assign base = mtvec & ~XLEN'(3);

`ifdef TRAP_VECTORED_EN
    assign trap_pc = mtvec[1:0] == 2'b01 && trap_cause[XLEN-1] ? base + {trap_cause[XLEN-3:0], 2'b00} : base;
`else
    assign trap_pc = base;
`endif
endmodule

// File: tb/tb_trap_ctrl.sv
// tb_trap_ctrl: directed checks of trap_ctrl arbitration, handshake, squash and trap_pc.
module tb_trap_ctrl;
    logic        clk = 0, rst = 1;
    logic [95:0] stage_pc = {32'h10C, 32'h108, 32'h104};
    logic [2:0]  exc_valid = '0;
    logic [95:0] exc_cause = {32'd4, 32'd2, 32'd1};
    logic [95:0] exc_val = {32'h2003, 32'h55, 32'h11};
    logic [15:0] irq_pending = '0, irq_enable = '0;
    logic        global_ie = 0;
    logic [31:0] mtvec = 32'h1000;
    logic        trap_insert = 0, mret = 0;
    logic        trap_req, in_handler;
    logic [31:0] trap_pc, trap_epc, trap_cause, trap_val;
    logic [2:0]  squash;
    int checks = 0, errors = 0;

    trap_ctrl dut (
        .clk(clk), .rst(rst), .stage_pc(stage_pc), .exc_valid(exc_valid),
        .exc_cause(exc_cause), .exc_val(exc_val), .irq_pending(irq_pending),
        .irq_enable(irq_enable), .global_ie(global_ie), .mtvec(mtvec),
        .trap_insert(trap_insert), .mret(mret), .trap_req(trap_req),
        .trap_pc(trap_pc), .trap_epc(trap_epc), .trap_cause(trap_cause),
        .trap_val(trap_val), .squash(squash), .in_handler(in_handler)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tick();
        check("rst_req", {31'b0, trap_req}, 0);
        check("rst_epc", trap_epc, 0);
        check("rst_hdl", {31'b0, in_handler}, 0);
        rst = 0;
        // reset while PENDING
        exc_valid = 3'b001;
        tick();
        exc_valid = 3'b000;
        check("pend_req", {31'b0, trap_req}, 1);
        rst = 1;
        #1;
        check("arst_req", {31'b0, trap_req}, 0);
        check("arst_cause", trap_cause, 0);
        check("arst_sq", {29'b0, squash}, 0);
        rst = 0;
        trap_insert = 1;
        tick();
        trap_insert = 0;
        check("ins_idle_hdl", {31'b0, in_handler}, 0);
        check("ins_idle_req", {31'b0, trap_req}, 0);
        // stages 0 and 1 fault: stage 1 wins
        exc_valid = 3'b011;
        tick();
        exc_valid = 3'b000;
        check("s1_req", {31'b0, trap_req}, 1);
        check("s1_epc", trap_epc, 32'h108);
        check("s1_cause", trap_cause, 2);
        check("s1_val", trap_val, 32'h55);
        check("s1_sq", {29'b0, squash}, 3'b011);
        tick();
        check("s1_sq_pulse", {29'b0, squash}, 0);
        check("s1_hold", trap_epc, 32'h108);
        trap_insert = 1;
        tick();
        trap_insert = 0;
        check("ins_hdl", {31'b0, in_handler}, 1);
        check("ins_req", {31'b0, trap_req}, 0);
        mret = 1;
        tick();
        mret = 0;
        check("mret_idle", {31'b0, in_handler}, 0);
        // overwrite by older stage, no overwrite by younger
        exc_valid = 3'b001;
        tick();
        check("s0_cause", trap_cause, 1);
        check("s0_sq", {29'b0, squash}, 3'b001);
        exc_valid = 3'b100;
        tick();
        check("ow_cause", trap_cause, 4);
        check("ow_val", trap_val, 32'h2003);
        check("ow_epc", trap_epc, 32'h10C);
        check("ow_sq", {29'b0, squash}, 3'b111);
        exc_valid = 3'b010;
        tick();
        exc_valid = 3'b000;
        check("no_ow_cause", trap_cause, 4);
        check("no_ow_sq", {29'b0, squash}, 0);
        trap_insert = 1;
        tick();
        trap_insert = 0;
        mret = 1;
        tick();
        mret = 0;
        // global_ie masks everything
        irq_pending = 16'h0880;
        irq_enable = 16'hFFFF;
        tick();
        check("gie_off", {31'b0, trap_req}, 0);
        // exception beats simultaneous interrupt
        global_ie = 1;
        exc_valid = 3'b010;
        tick();
        exc_valid = 3'b000;
        check("exc_vs_irq", trap_cause, 2);
        check("exc_vs_irq_sq", {29'b0, squash}, 3'b011);
        mtvec = 32'h1001;
        check("pc_exc_base", trap_pc, 32'h1000);
        tick();
        check("irq_no_ow", trap_cause, 2);
        trap_insert = 1;
        tick();
        trap_insert = 0;
        tick();
        check("irq_ign_hdl", {31'b0, in_handler}, 1);
        check("irq_ign_cause", trap_cause, 2);
        mret = 1;
        tick();
        mret = 0;
        check("mret_req", {31'b0, trap_req}, 0);
        tick();
        check("irq_req", {31'b0, trap_req}, 1);
        check("irq_cause", trap_cause, 32'h80000007);
        check("irq_epc", trap_epc, 32'h104);
        check("irq_val", trap_val, 0);
        check("irq_sq", {29'b0, squash}, 0);
        // any exception overwrites a latched interrupt
        exc_valid = 3'b001;
        tick();
        check("exc_ow_irq", trap_cause, 1);
        check("exc_ow_irq_sq", {29'b0, squash}, 3'b001);
        // overwrite and insert in the same cycle
        exc_valid = 3'b100;
        trap_insert = 1;
        tick();
        exc_valid = 3'b000;
        trap_insert = 0;
        check("ow_ins_hdl", {31'b0, in_handler}, 1);
        check("ow_ins_cause", trap_cause, 4);
        // nested exception beats mret
        exc_valid = 3'b010;
        mret = 1;
        tick();
        exc_valid = 3'b000;
        mret = 0;
        check("nest_req", {31'b0, trap_req}, 1);
        check("nest_cause", trap_cause, 2);
        check("nest_sq", {29'b0, squash}, 3'b011);
        trap_insert = 1;
        tick();
        trap_insert = 0;
        mret = 1;
        irq_pending = 16'h0800;
        tick();
        mret = 0;
        tick();
        check("vec_cause", trap_cause, 32'h8000000B);
`ifdef TRAP_VECTORED_EN
        check("vec_pc", trap_pc, 32'h102C);
`else
        check("vec_pc", trap_pc, 32'h1000);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
